draw_crosshair: RTL and testbench

Final overlay stage after `top_game`: takes the composed game video stream and draws the player's crosshair at the mouse position. The crosshair position is sampled once per frame so it never tears mid-frame. A left-click starts a multi-frame red "shot flash" in which the arms lengthen. The block is a 2-stage pipeline; all timing signals are delayed to stay aligned with rgb.

---
 rtl/draw_crosshair.sv | 246 ++++++++++++++++++++++++
 tb/tb_draw_crosshair.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_crosshair.sv
// Crosshair overlay on the composed game video stream: two-stage pipeline,
// with the cursor position latched once per frame and a multi-frame red shot flash.
module draw_crosshair #(
    parameter int          ARM_LEN      = 8,
    parameter int          GAP          = 3,
    parameter int          THICK        = 1,
    parameter logic [11:0] COLOUR       = 12'hFFF,
    parameter logic [11:0] FLASH_COLOUR = 12'hF00,
    parameter int          FLASH_FRAMES = 6,
    parameter int          FLASH_GROW   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        left_mouse,

    input  logic [10:0] in_hcount,
    input  logic [10:0] in_vcount,
    input  logic        in_hsync,
    input  logic        in_vsync,
    input  logic        in_hblnk,
    input  logic        in_vblnk,
    input  logic [11:0] in_rgb,

    output logic [10:0] out_hcount,
    output logic [10:0] out_vcount,
    output logic        out_hsync,
    output logic        out_vsync,
    output logic        out_hblnk,
    output logic        out_vblnk,
    output logic [11:0] out_rgb
);

    localparam int FCW = ($clog2(FLASH_FRAMES + 1) > 3) ? $clog2(FLASH_FRAMES + 1) : 3;
    localparam logic [FCW-1:0] FLASH_LOAD = FCW'(FLASH_FRAMES);
    localparam logic [12:0]    ARM_C      = 13'(ARM_LEN);
    localparam logic [12:0]    GROW_C     = 13'(FLASH_GROW);
    localparam logic [12:0]    GAP_C      = 13'(GAP);
    localparam logic [12:0]    THICK_C    = 13'(THICK);

    typedef enum logic {
        IDLE  = 1'b0,
        FLASH = 1'b1
    } state_t;

    // ---------------- frame tick, click detect, cursor latch ----------------
    logic        vblnk_q;
    logic        left_q;
    logic [11:0] cx_q, cx_d;
    logic [11:0] cy_q, cy_d;
    logic        frame_tick;
    logic        press;

    assign frame_tick = in_vblnk & ~vblnk_q;
    assign press      = left_mouse & ~left_q;

    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (frame_tick) begin
            cx_d = mouse_xpos;
            cy_d = mouse_ypos;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_q <= 1'b0;
            left_q  <= 1'b0;
            cx_q    <= '0;
            cy_q    <= '0;
        end else begin
            vblnk_q <= in_vblnk;
            left_q  <= left_mouse;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
        end
    end

    // ---------------- flash state machine ----------------
    state_t         state_q, state_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // A press always reloads, even when it coincides with a frame tick.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (!enable) begin
            state_d = IDLE;
            fcnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (press) begin
                        fcnt_d  = FLASH_LOAD;
                        state_d = FLASH;
                    end
                end
                FLASH: begin
                    if (press) begin
                        fcnt_d = FLASH_LOAD;
                    end else if (frame_tick) begin
                        fcnt_d = fcnt_q - 1'b1;
                        if (fcnt_q <= FCW'(1)) begin
                            fcnt_d  = '0;
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    fcnt_d  = '0;
                end
            endcase
        end
    end

    // ---------------- stage 1: distances ----------------
    logic signed [12:0] dx_diff, dy_diff;
    logic [10:0] hcount_s1_q, hcount_s1_d;
    logic [10:0] vcount_s1_q, vcount_s1_d;
    logic        hsync_s1_q, hsync_s1_d;
    logic        vsync_s1_q, vsync_s1_d;
    logic        hblnk_s1_q, hblnk_s1_d;
    logic        vblnk_s1_q, vblnk_s1_d;
    logic [11:0] rgb_s1_q, rgb_s1_d;
    logic [11:0] dx_s1_q, dx_s1_d;
    logic [11:0] dy_s1_q, dy_s1_d;
    logic        flash_s1_q, flash_s1_d;

    // Zero-extended operands keep the subtraction from wrapping near x=0 / y=0.
    assign dx_diff = $signed({2'b00, in_hcount}) - $signed({1'b0, cx_q});
    assign dy_diff = $signed({2'b00, in_vcount}) - $signed({1'b0, cy_q});

    always_comb begin
        hcount_s1_d = in_hcount;
        vcount_s1_d = in_vcount;
        hsync_s1_d  = in_hsync;
        vsync_s1_d  = in_vsync;
        hblnk_s1_d  = in_hblnk;
        vblnk_s1_d  = in_vblnk;
        rgb_s1_d    = in_rgb;
        dx_s1_d     = dx_diff[12] ? (~dx_diff[11:0] + 12'd1) : dx_diff[11:0];
        dy_s1_d     = dy_diff[12] ? (~dy_diff[11:0] + 12'd1) : dy_diff[11:0];
        flash_s1_d  = (state_q == FLASH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_s1_q <= '0;
            vcount_s1_q <= '0;
            hsync_s1_q  <= 1'b0;
            vsync_s1_q  <= 1'b0;
            hblnk_s1_q  <= 1'b0;
            vblnk_s1_q  <= 1'b0;
            rgb_s1_q    <= '0;
            dx_s1_q     <= '0;
            dy_s1_q     <= '0;
            flash_s1_q  <= 1'b0;
        end else begin
            hcount_s1_q <= hcount_s1_d;
            vcount_s1_q <= vcount_s1_d;
            hsync_s1_q  <= hsync_s1_d;
            vsync_s1_q  <= vsync_s1_d;
            hblnk_s1_q  <= hblnk_s1_d;
            vblnk_s1_q  <= vblnk_s1_d;
            rgb_s1_q    <= rgb_s1_d;
            dx_s1_q     <= dx_s1_d;
            dy_s1_q     <= dy_s1_d;
            flash_s1_q  <= flash_s1_d;
        end
    end

    // ---------------- stage 2: hit test and colour ----------------
    logic [12:0] arm_len;
    logic [12:0] dx_ext, dy_ext;
    logic        hit;
    logic [10:0] out_hcount_q, out_hcount_d;
    logic [10:0] out_vcount_q, out_vcount_d;
    logic        out_hsync_q, out_hsync_d;
    logic        out_vsync_q, out_vsync_d;
    logic        out_hblnk_q, out_hblnk_d;
    logic        out_vblnk_q, out_vblnk_d;
    logic [11:0] out_rgb_q, out_rgb_d;

    assign arm_len = ARM_C + (flash_s1_q ? GROW_C : 13'd0);
    assign dx_ext  = {1'b0, dx_s1_q};
    assign dy_ext  = {1'b0, dy_s1_q};
    assign hit     = ((dy_ext <= THICK_C) && (dx_ext > GAP_C) && (dx_ext <= arm_len))
                  || ((dx_ext <= THICK_C) && (dy_ext > GAP_C) && (dy_ext <= arm_len))
                  || ((dx_s1_q == 12'd0) && (dy_s1_q == 12'd0));

    always_comb begin
        out_hcount_d = hcount_s1_q;
        out_vcount_d = vcount_s1_q;
        out_hsync_d  = hsync_s1_q;
        out_vsync_d  = vsync_s1_q;
        out_hblnk_d  = hblnk_s1_q;
        out_vblnk_d  = vblnk_s1_q;
        out_rgb_d    = rgb_s1_q;
        if (enable && hit && !hblnk_s1_q && !vblnk_s1_q) begin
            out_rgb_d = flash_s1_q ? FLASH_COLOUR : COLOUR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_hcount_q <= '0;
            out_vcount_q <= '0;
            out_hsync_q  <= 1'b0;
            out_vsync_q  <= 1'b0;
            out_hblnk_q  <= 1'b0;
            out_vblnk_q  <= 1'b0;
            out_rgb_q    <= '0;
        end else begin
            out_hcount_q <= out_hcount_d;
            out_vcount_q <= out_vcount_d;
            out_hsync_q  <= out_hsync_d;
            out_vsync_q  <= out_vsync_d;
            out_hblnk_q  <= out_hblnk_d;
            out_vblnk_q  <= out_vblnk_d;
            out_rgb_q    <= out_rgb_d;
        end
    end

    assign out_hcount = out_hcount_q;
    assign out_vcount = out_vcount_q;
    assign out_hsync  = out_hsync_q;
    assign out_vsync  = out_vsync_q;
    assign out_hblnk  = out_hblnk_q;
    assign out_vblnk  = out_vblnk_q;
    assign out_rgb    = out_rgb_q;

endmodule

// File: tb/tb_draw_crosshair.sv
// Bench for draw_crosshair: hand-computed pixel table, directed flash/reset/latch
// sequences and a randomized stream checked against a frame-level reference model.
module tb_draw_crosshair;

    localparam int          ARM_LEN      = 8;
    localparam int          GAP          = 3;
    localparam int          THICK        = 1;
    localparam logic [11:0] COLOUR       = 12'hFFF;
    localparam logic [11:0] FLASH_COLOUR = 12'hF00;
    localparam int          FLASH_FRAMES = 6;
    localparam int          FLASH_GROW   = 4;
    localparam logic [11:0] BG           = 12'h0A0;

    logic        clk = 1'b0;
    logic        rst, enable, left_mouse;
    logic [11:0] mouse_xpos, mouse_ypos;
    logic [10:0] in_hcount, in_vcount;
    logic        in_hsync, in_vsync, in_hblnk, in_vblnk;
    logic [11:0] in_rgb;
    logic [10:0] out_hcount, out_vcount;
    logic        out_hsync, out_vsync, out_hblnk, out_vblnk;
    logic [11:0] out_rgb;

    always #5 clk = ~clk;

    draw_crosshair #(
        .ARM_LEN(ARM_LEN), .GAP(GAP), .THICK(THICK), .COLOUR(COLOUR),
        .FLASH_COLOUR(FLASH_COLOUR), .FLASH_FRAMES(FLASH_FRAMES), .FLASH_GROW(FLASH_GROW)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos), .left_mouse(left_mouse),
        .in_hcount(in_hcount), .in_vcount(in_vcount), .in_hsync(in_hsync),
        .in_vsync(in_vsync), .in_hblnk(in_hblnk), .in_vblnk(in_vblnk), .in_rgb(in_rgb),
        .out_hcount(out_hcount), .out_vcount(out_vcount), .out_hsync(out_hsync),
        .out_vsync(out_vsync), .out_hblnk(out_hblnk), .out_vblnk(out_vblnk), .out_rgb(out_rgb)
    );

    int n_vec = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    typedef struct {
        int hc, vc, hs, vs, hb, vb, rgb;
        int cx, cy;
        bit flash;
    } pix_t;

    int   m_cx, m_cy, m_fcnt;
    bit   m_vb_prev, m_left_prev;
    pix_t m_s1;
    int   e_hc, e_vc, e_hs, e_vs, e_hb, e_vb, e_rgb;

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic bit on_crosshair(int px, int py, int cx, int cy, bit flash);
        int dx, dy, len;
        dx  = iabs(px - cx);
        dy  = iabs(py - cy);
        len = ARM_LEN + (flash ? FLASH_GROW : 0);
        if (dx == 0 && dy == 0) return 1'b1;
        if (dy <= THICK && dx > GAP && dx <= len) return 1'b1;
        if (dx <= THICK && dy > GAP && dy <= len) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        m_cx = 0; m_cy = 0; m_fcnt = 0; m_vb_prev = 0; m_left_prev = 0;
        m_s1 = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0};
        e_hc = 0; e_vc = 0; e_hs = 0; e_vs = 0; e_hb = 0; e_vb = 0; e_rgb = 0;
    endtask

    // Called right at the clock edge, with the inputs the DUT is sampling.
    task automatic model_step();
        bit tick, press;
        if (rst) begin
            model_clear();
            return;
        end
        e_hc = m_s1.hc; e_vc = m_s1.vc; e_hs = m_s1.hs; e_vs = m_s1.vs;
        e_hb = m_s1.hb; e_vb = m_s1.vb; e_rgb = m_s1.rgb;
        if (enable && m_s1.hb == 0 && m_s1.vb == 0 &&
            on_crosshair(m_s1.hc, m_s1.vc, m_s1.cx, m_s1.cy, m_s1.flash))
            e_rgb = m_s1.flash ? int'(FLASH_COLOUR) : int'(COLOUR);
        m_s1 = '{int'(in_hcount), int'(in_vcount), int'(in_hsync), int'(in_vsync),
                 int'(in_hblnk), int'(in_vblnk), int'(in_rgb), m_cx, m_cy, (m_fcnt > 0)};
        tick  = in_vblnk && !m_vb_prev;
        press = left_mouse && !m_left_prev;
        if (tick) begin
            m_cx = int'(mouse_xpos);
            m_cy = int'(mouse_ypos);
        end
        if (!enable)                  m_fcnt = 0;
        else if (press)               m_fcnt = FLASH_FRAMES;
        else if (tick && m_fcnt > 0)  m_fcnt = m_fcnt - 1;
        m_vb_prev   = in_vblnk;
        m_left_prev = left_mouse;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick_check();
        @(posedge clk);
        model_step();
        #1;
        n_vec++;
        if (int'(out_hcount) != e_hc || int'(out_vcount) != e_vc || int'(out_hsync) != e_hs ||
            int'(out_vsync) != e_vs || int'(out_hblnk) != e_hb || int'(out_vblnk) != e_vb ||
            int'(out_rgb) != e_rgb) begin
            n_bad++;
            $display("FAIL stream t=%0t: got h=%0d v=%0d hs=%0b vs=%0b hb=%0b vb=%0b rgb=%h, want h=%0d v=%0d hs=%0d vs=%0d hb=%0d vb=%0d rgb=%h",
                     $time, out_hcount, out_vcount, out_hsync, out_vsync, out_hblnk, out_vblnk,
                     out_rgb, e_hc, e_vc, e_hs, e_vs, e_hb, e_vb, e_rgb[11:0]);
        end
    endtask

    task automatic frame_pulse();
        in_vblnk = 1'b1;
        tick_check();
        in_vblnk = 1'b0;
        tick_check();
    endtask

    task automatic probe(input string name, input int hc, input int vc, input logic [11:0] exp_rgb);
        in_hcount = 11'(hc);
        in_vcount = 11'(vc);
        tick_check();
        tick_check();
        n_vec++;
        if (out_rgb !== exp_rgb || int'(out_hcount) != hc || int'(out_vcount) != vc) begin
            n_bad++;
            $display("FAIL %s (%0d,%0d): got rgb=%h at (%0d,%0d), want rgb=%h", name, hc, vc,
                     out_rgb, out_hcount, out_vcount, exp_rgb);
        end else
            $display("probe %s (%0d,%0d) rgb=%h", name, hc, vc, out_rgb);
    endtask

    task automatic check_zero(input string name);
        n_vec++;
        if (out_hcount !== 0 || out_vcount !== 0 || out_hsync !== 0 || out_vsync !== 0 ||
            out_hblnk !== 0 || out_vblnk !== 0 || out_rgb !== 0) begin
            n_bad++;
            $display("FAIL %s: got h=%0d v=%0d hs=%0b vs=%0b hb=%0b vb=%0b rgb=%h, want all 0", name,
                     out_hcount, out_vcount, out_hsync, out_vsync, out_hblnk, out_vblnk, out_rgb);
        end else
            $display("check %s: outputs all 0", name);
    endtask

    task automatic press_pulse();
        left_mouse = 1'b1;
        tick_check();
        left_mouse = 1'b0;
        tick_check();
    endtask

    // ---------------- hand-computed vectors ----------------
    typedef struct {
        string       name;
        int          mx, my;
        bit          en, hb;
        int          hc, vc;
        logic [11:0] exp_rgb;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int cur_mx, cur_my;

        tbl.push_back('{"arm_left_end",   400, 300, 1, 0, 392, 300, COLOUR});
        tbl.push_back('{"arm_left_in",    400, 300, 1, 0, 396, 300, COLOUR});
        tbl.push_back('{"gap_left",       400, 300, 1, 0, 397, 300, BG});
        tbl.push_back('{"centre",         400, 300, 1, 0, 400, 300, COLOUR});
        tbl.push_back('{"arm_right_top",  400, 300, 1, 0, 404, 299, COLOUR});
        tbl.push_back('{"arm_right_bot",  400, 300, 1, 0, 408, 301, COLOUR});
        tbl.push_back('{"past_right",     400, 300, 1, 0, 409, 300, BG});
        tbl.push_back('{"arm_up_end",     400, 300, 1, 0, 400, 292, COLOUR});
        tbl.push_back('{"past_up",        400, 300, 1, 0, 400, 291, BG});
        tbl.push_back('{"diag",           400, 300, 1, 0, 401, 301, BG});
        tbl.push_back('{"thick_edge",     400, 300, 1, 0, 395, 302, BG});
        tbl.push_back('{"hblank",         400, 300, 1, 1, 400, 300, BG});
        tbl.push_back('{"disabled",       400, 300, 0, 0, 392, 300, BG});
        tbl.push_back('{"clip_00",          2,   0, 1, 0,   0,   0, BG});
        tbl.push_back('{"clip_10",          2,   0, 1, 0,   1,   0, BG});
        tbl.push_back('{"clip_centre",      2,   0, 1, 0,   2,   0, COLOUR});
        tbl.push_back('{"clip_arm",         2,   0, 1, 0,  10,   0, COLOUR});
        tbl.push_back('{"clip_past",        2,   0, 1, 0,  11,   0, BG});
        tbl.push_back('{"clip_down",        2,   0, 1, 0,   2,   5, COLOUR});
        tbl.push_back('{"no_wrap_x",        2,   0, 1, 0, 1023,  0, BG});
        tbl.push_back('{"no_wrap_y",        2,   0, 1, 0,   2, 767, BG});
        tbl.push_back('{"offscreen",     4095,4095, 1, 0, 2047,   0, BG});
        tbl.push_back('{"offscreen_b",   4095,4095, 1, 0, 2047,2047, BG});

        rst = 1'b1; enable = 1'b1; left_mouse = 1'b0;
        mouse_xpos = 12'd0; mouse_ypos = 12'd0;
        in_hcount = '0; in_vcount = '0; in_hsync = 1'b0; in_vsync = 1'b0;
        in_hblnk = 1'b0; in_vblnk = 1'b0; in_rgb = BG;
        model_clear();
        repeat (3) tick_check();
        check_zero("reset_state");
        rst = 1'b0;

        // Table
        cur_mx = -1; cur_my = -1;
        foreach (tbl[i]) begin
            enable = 1'b1;
            in_hblnk = 1'b0;
            if (tbl[i].mx != cur_mx || tbl[i].my != cur_my) begin
                mouse_xpos = 12'(tbl[i].mx);
                mouse_ypos = 12'(tbl[i].my);
                frame_pulse();
                cur_mx = tbl[i].mx; cur_my = tbl[i].my;
            end
            enable   = tbl[i].en;
            in_hblnk = tbl[i].hb;
            probe(tbl[i].name, tbl[i].hc, tbl[i].vc, tbl[i].exp_rgb);
        end
        enable = 1'b1; in_hblnk = 1'b0;

        // Frame-synchronous latch
        mouse_xpos = 12'd100; mouse_ypos = 12'd100;
        frame_pulse();
        mouse_xpos = 12'd500; mouse_ypos = 12'd500;
        probe("latch_old_centre", 100, 100, COLOUR);
        probe("latch_old_arm", 104, 100, COLOUR);
        probe("latch_new_not_yet", 500, 500, BG);
        frame_pulse();
        probe("latch_new_centre", 500, 500, COLOUR);
        probe("latch_old_gone", 100, 100, BG);

        // Flash with the button held throughout
        mouse_xpos = 12'd400; mouse_ypos = 12'd300;
        frame_pulse();
        left_mouse = 1'b1;
        tick_check();
        probe("flash_past_len", 413, 300, BG);
        for (int f = 0; f < FLASH_FRAMES; f++) begin
            probe($sformatf("flash_arm_f%0d", f), 412, 300, FLASH_COLOUR);
            frame_pulse();
        end
        probe("flash_over_len", 412, 300, BG);
        probe("flash_over_col", 408, 300, COLOUR);
        left_mouse = 1'b0;
        tick_check();

        // Retrigger coinciding with a frame tick at fcnt=2
        press_pulse();
        repeat (FLASH_FRAMES - 2) frame_pulse();
        left_mouse = 1'b1; in_vblnk = 1'b1;
        tick_check();
        left_mouse = 1'b0; in_vblnk = 1'b0;
        tick_check();
        for (int f = 0; f < FLASH_FRAMES; f++) begin
            probe($sformatf("retrig_f%0d", f), 412, 300, FLASH_COLOUR);
            frame_pulse();
        end
        probe("retrig_over", 412, 300, BG);

        // Reset mid-flash
        press_pulse();
        probe("pre_rst_flash", 400, 300, FLASH_COLOUR);
        in_hsync = 1'b1; in_vsync = 1'b1;
        rst = 1'b1;
        tick_check();
        check_zero("rst_mid_flash");
        rst = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0;
        probe("post_rst_centre", 0, 0, COLOUR);
        probe("post_rst_arm", 5, 0, COLOUR);
        probe("post_rst_noflash", 12, 0, BG);
        frame_pulse();
        probe("post_rst_relatch", 400, 300, COLOUR);

        // Randomized pass-through with enable low
        enable = 1'b0;
        for (int c = 0; c < 300; c++) begin
            in_hcount  = 11'($urandom);
            in_vcount  = 11'($urandom);
            in_hsync   = 1'($urandom);
            in_vsync   = 1'($urandom);
            in_hblnk   = 1'($urandom);
            in_vblnk   = 1'($urandom);
            in_rgb     = 12'($urandom);
            left_mouse = 1'($urandom);
            mouse_xpos = 12'($urandom_range(0, 1100));
            mouse_ypos = 12'($urandom_range(0, 800));
            tick_check();
        end

        // Randomized overlay near the cursor
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 499) == 0);
            enable     = ($urandom_range(0, 15) != 0);
            in_vblnk   = ($urandom_range(0, 19) == 0);
            in_hblnk   = ($urandom_range(0, 9) == 0);
            in_hsync   = 1'($urandom);
            in_vsync   = 1'($urandom);
            left_mouse = ($urandom_range(0, 29) == 0);
            mouse_xpos = 12'($urandom_range(0, 20));
            mouse_ypos = 12'($urandom_range(0, 20));
            in_hcount  = 11'($urandom_range(0, 36));
            in_vcount  = 11'($urandom_range(0, 36));
            in_rgb     = 12'($urandom);
            tick_check();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
